// File: rtl/memory_access_unit.sv
// ---------------------------------------------------------------------------
// memory_access_unit
//
// MEM stage of a 64-bit pipeline. ALU-only instructions pass straight to the
// MEM/WB register in one cycle. Loads and stores are latched, and the unit
// moves to WAIT, where it drives a registered request to data memory until an
// ack arrives or the WAIT counter times out. A timeout aborts the access,
// emits a bubble and sets a sticky fault flag.
//
// Ports
//   clk              clock
//   reset            synchronous active-low reset
//   ex_valid         EX stage presents a valid instruction
//   EX_PIPELINE_REG  {ALU_result[63:0], store_data[63:0], instr[31:0],
//                     mem_read, mem_write, mem_to_reg, reg_write}
//   dmem_req/we/addr/wdata   registered data-memory request
//   dmem_rdata/ack   memory response
//   mem_stall        upstream holds its EX inputs while high
//   mem_wb_valid     MEM_PIPELINE_REG holds a real instruction
//   mem_fault        sticky timeout flag
//   MEM_PIPELINE_REG {ALU_result[63:0], read_data[63:0], instr[31:0],
//                     WriteData[63:0]}
// ---------------------------------------------------------------------------
module memory_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ex_valid,
    input  logic [163:0] EX_PIPELINE_REG,
    output logic         dmem_req,
    output logic         dmem_we,
    output logic [63:0]  dmem_addr,
    output logic [63:0]  dmem_wdata,
    input  logic [63:0]  dmem_rdata,
    input  logic         dmem_ack,
    output logic         mem_stall,
    output logic         mem_wb_valid,
    output logic         mem_fault,
    output logic [223:0] MEM_PIPELINE_REG
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [31:0]  XZR_INSTR = 32'h0000_001F;
    localparam logic [223:0] BUBBLE    = {64'd0, 64'd0, XZR_INSTR, 64'd0};
    // Last WAIT cycle index before an unanswered request is abandoned, so
    // the request stays up for exactly TIMEOUT cycles.
    localparam logic [7:0]   LAST_WAIT = 8'(TIMEOUT - 1);

    // EX field split
    logic [63:0] ex_alu;
    logic [63:0] ex_store;
    logic [31:0] ex_instr;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_mem_to_reg;
    logic        ex_reg_write;
    logic        ex_is_mem;

    assign {ex_alu, ex_store, ex_instr, ex_mem_read, ex_mem_write,
            ex_mem_to_reg, ex_reg_write} = EX_PIPELINE_REG;
    assign ex_is_mem = ex_mem_read | ex_mem_write;

    state_t       state_q;
    logic [7:0]   cnt_q;
    logic         dmem_req_q;
    logic         dmem_we_q;       // doubles as the latched mem_write
    logic [63:0]  dmem_addr_q;     // doubles as the latched ALU_result
    logic [63:0]  dmem_wdata_q;
    logic [31:0]  instr_q;
    logic         mem_read_q;
    logic         mem_to_reg_q;
    logic         reg_write_q;
    logic         wb_valid_q;
    logic         fault_q;
    logic [223:0] mem_pipe_q;

    logic timeout_now;
    assign timeout_now = (state_q == WAIT) && !dmem_ack && (cnt_q == LAST_WAIT);

    // Destination is redirected to XZR when the instruction does not write.
    function automatic logic [31:0] wb_instr(input logic [31:0] instr,
                                             input logic        rw);
        return rw ? instr : {instr[31:5], 5'd31};
    endfunction

    // Stall is combinational: raised in the accept cycle, held through WAIT
    // and released in the cycle that completes or abandons the access.
    always_comb begin
        mem_stall = 1'b0;
        if (reset) begin
            if (state_q == IDLE) begin
                mem_stall = ex_valid && ex_is_mem;
            end else begin
                mem_stall = !dmem_ack && !timeout_now;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= 64'd0;
            dmem_wdata_q <= 64'd0;
            instr_q      <= 32'd0;
            mem_read_q   <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            wb_valid_q   <= 1'b0;
            fault_q      <= 1'b0;
            mem_pipe_q   <= BUBBLE;
        end else begin
            // Every cycle that does not retire an instruction emits a bubble.
            wb_valid_q <= 1'b0;
            mem_pipe_q <= BUBBLE;
            case (state_q)
                IDLE: begin
                    if (ex_valid) begin
                        if (ex_is_mem) begin
                            state_q      <= WAIT;
                            cnt_q        <= 8'd0;
                            dmem_req_q   <= 1'b1;
                            dmem_we_q    <= ex_mem_write;
                            dmem_addr_q  <= ex_alu;
                            dmem_wdata_q <= ex_store;
                            instr_q      <= ex_instr;
                            mem_read_q   <= ex_mem_read;
                            mem_to_reg_q <= ex_mem_to_reg;
                            reg_write_q  <= ex_reg_write;
                        end else begin
                            wb_valid_q <= 1'b1;
                            mem_pipe_q <= {ex_alu, 64'd0,
                                           wb_instr(ex_instr, ex_reg_write),
                                           ex_alu};
                        end
                    end
                end
                WAIT: begin
                    // Ack wins over a coincident timeout.
                    if (dmem_ack) begin
                        state_q    <= IDLE;
                        dmem_req_q <= 1'b0;
                        wb_valid_q <= 1'b1;
                        mem_pipe_q <= {dmem_addr_q,
                                       (mem_read_q && !dmem_we_q) ? dmem_rdata : 64'd0,
                                       wb_instr(instr_q, reg_write_q),
                                       mem_to_reg_q ? dmem_rdata : dmem_addr_q};
                    end else if (cnt_q == LAST_WAIT) begin
                        state_q    <= IDLE;
                        dmem_req_q <= 1'b0;
                        fault_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dmem_req         = dmem_req_q;
    assign dmem_we          = dmem_we_q;
    assign dmem_addr        = dmem_addr_q;
    assign dmem_wdata       = dmem_wdata_q;
    assign mem_wb_valid     = wb_valid_q;
    assign mem_fault        = fault_q;
    assign MEM_PIPELINE_REG = mem_pipe_q;

endmodule
